// File: rtl/frequency_counter.sv
// frequency_counter: counts synchronized rising edges of signal_i over a fixed gate window
// and publishes the saturated count with a one-cycle valid strobe.
module frequency_counter #(
  parameter int WORD_LENGTH    = 16,
  parameter int FREQUENCY_IN   = 100000000,
  parameter int GATE_FREQUENCY = 1000
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   signal_i,
  output logic [WORD_LENGTH-1:0] count_o,
  output logic                   valid_o,
  output logic                   overflow_o
);
  localparam int GATE_CYCLES = FREQUENCY_IN / GATE_FREQUENCY;
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, r_hist;
  logic [GW-1:0] r_gate;
  logic [WORD_LENGTH-1:0] r_acc, r_count, w_acc;
  logic r_ovf, r_valid, r_overflow;
  logic w_edge, w_ovf, w_end, w_run;
  always_comb begin
    w_edge = r_sync2 & ~r_hist;
    w_acc  = (w_edge && r_acc != '1) ? r_acc + 1'b1 : r_acc;
    w_ovf  = r_ovf | (w_edge & (r_acc == '1));
    w_end  = r_gate == GATE_LAST;
    w_run  = (r_state == MEASURE) && enable_i;
    w_next = enable_i ? MEASURE : IDLE;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hist     <= 1'b0;
      r_gate     <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync1 <= signal_i;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_valid <= 1'b0;
      // a disable on the window-end edge discards the window instead of publishing it
      if (w_run && w_end) begin
        r_count    <= w_acc;
        r_overflow <= w_ovf;
        r_valid    <= 1'b1;
        r_gate     <= '0;
        r_acc      <= '0;
        r_ovf      <= 1'b0;
      end else if (w_run) begin
        r_gate <= r_gate + 1'b1;
        r_acc  <= w_acc;
        r_ovf  <= w_ovf;
      end else begin
        r_gate <= '0;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
      end
    end
  end
  assign count_o    = r_count;
  assign valid_o    = r_valid;
  assign overflow_o = r_overflow;
endmodule

// File: tb/tb_frequency_counter.sv
// tb_frequency_counter: directed scenarios on a 16-bit and a 4-bit counter sharing one stimulus,
// with a 100-cycle gate window.
module tb_frequency_counter;
  logic clk = 1'b0;
  logic rst_n, en, sig;
  logic [15:0] c16;
  logic [3:0] c4;
  logic v16, v4, o16, o4;
  int per = 0;
  int npass = 0;
  int ntotal = 0;
  frequency_counter #(.WORD_LENGTH(16), .FREQUENCY_IN(1000), .GATE_FREQUENCY(10)) u16 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .signal_i(sig),
    .count_o(c16), .valid_o(v16), .overflow_o(o16)
  );
  frequency_counter #(.WORD_LENGTH(4), .FREQUENCY_IN(1000), .GATE_FREQUENCY(10)) u4 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .signal_i(sig),
    .count_o(c4), .valid_o(v4), .overflow_o(o4)
  );
  always #5 clk = ~clk;
  // periodic square wave on signal_i while per != 0; otherwise the tests drive sig directly
  initial begin : gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (per != 0) begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        sig = (ph < per / 2);
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic wait_valid(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (n < 300 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = v16;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    ntotal++; if (c16 !== 16'd0) $display("FAIL reset_count16: got %0d want 0", c16); else npass++;
    ntotal++; if (v16 !== 1'b0) $display("FAIL reset_valid16: got %0b want 0", v16); else npass++;
    ntotal++; if (o16 !== 1'b0) $display("FAIL reset_ovf16: got %0b want 0", o16); else npass++;
    ntotal++; if (c4 !== 4'd0) $display("FAIL reset_count4: got %0d want 0", c4); else npass++;
    ntotal++; if (v4 !== 1'b0) $display("FAIL reset_valid4: got %0b want 0", v4); else npass++;
    ntotal++; if (o4 !== 1'b0) $display("FAIL reset_ovf4: got %0b want 0", o4); else npass++;
    rst_n = 1'b1;
  endtask
  task automatic test_steady;
    bit seen;
    int n;
    per = 10;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      seen |= v16;
    end
    ntotal++; if (seen !== 1'b0) $display("FAIL idle_no_valid: got %0b want 0", seen); else npass++;
    en = 1'b1;
    @(posedge clk);
    wait_valid(n);
    ntotal++; if (n != 100) $display("FAIL steady_first_latency: got %0d want 100", n); else npass++;
    ntotal++; if (c16 !== 16'd9 && c16 !== 16'd10) $display("FAIL steady_first_count: got %0d want 9 or 10", c16); else npass++;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      ntotal++; if (n != 100) $display("FAIL steady_period[%0d]: got %0d want 100", i, n); else npass++;
      ntotal++; if (c16 !== 16'd10) $display("FAIL steady_count[%0d]: got %0d want 10", i, c16); else npass++;
      ntotal++; if (o16 !== 1'b0) $display("FAIL steady_ovf[%0d]: got %0b want 0", i, o16); else npass++;
    end
  endtask
  task automatic test_enable_drop;
    bit seen;
    int n;
    repeat (50) @(negedge clk);
    en = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      seen |= v16;
    end
    ntotal++; if (seen !== 1'b0) $display("FAIL drop_no_valid: got %0b want 0", seen); else npass++;
    ntotal++; if (c16 !== 16'd10) $display("FAIL drop_count_held: got %0d want 10", c16); else npass++;
    en = 1'b1;
    @(posedge clk);
    wait_valid(n);
    ntotal++; if (n != 100) $display("FAIL drop_reenable_latency: got %0d want 100", n); else npass++;
    ntotal++; if (c16 !== 16'd10) $display("FAIL drop_reenable_count: got %0d want 10", c16); else npass++;
  endtask
  task automatic test_reset_mid;
    int n;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    ntotal++; if (c16 !== 16'd0) $display("FAIL midreset_count: got %0d want 0", c16); else npass++;
    ntotal++; if (v16 !== 1'b0) $display("FAIL midreset_valid: got %0b want 0", v16); else npass++;
    ntotal++; if (o16 !== 1'b0) $display("FAIL midreset_ovf: got %0b want 0", o16); else npass++;
    rst_n = 1'b1;
    @(posedge clk);
    wait_valid(n);
    ntotal++; if (n != 100) $display("FAIL midreset_latency: got %0d want 100", n); else npass++;
    wait_valid(n);
    ntotal++; if (c16 !== 16'd10) $display("FAIL midreset_count_after: got %0d want 10", c16); else npass++;
  endtask
  task automatic test_overflow;
    int n;
    per = 4;
    wait_valid(n);
    wait_valid(n);
    ntotal++; if (v4 !== 1'b1) $display("FAIL ovf_valid4: got %0b want 1", v4); else npass++;
    ntotal++; if (c4 !== 4'd15) $display("FAIL ovf_count4: got %0d want 15", c4); else npass++;
    ntotal++; if (o4 !== 1'b1) $display("FAIL ovf_flag4: got %0b want 1", o4); else npass++;
    ntotal++; if (c16 !== 16'd25 || o16 !== 1'b0) $display("FAIL ovf_count16: got %0d/%0b want 25/0", c16, o16); else npass++;
    per = 10;
    wait_valid(n);
    wait_valid(n);
    ntotal++; if (n != 100) $display("FAIL ovf_recover_period: got %0d want 100", n); else npass++;
    ntotal++; if (c4 !== 4'd10) $display("FAIL ovf_recover_count4: got %0d want 10", c4); else npass++;
    ntotal++; if (o4 !== 1'b0) $display("FAIL ovf_recover_flag4: got %0b want 0", o4); else npass++;
  endtask
  task automatic test_constant;
    int n;
    per = 0;
    @(negedge clk);
    sig = 1'b0;
    wait_valid(n);
    wait_valid(n);
    ntotal++; if (c16 !== 16'd0) $display("FAIL const_low_a: got %0d want 0", c16); else npass++;
    wait_valid(n);
    ntotal++; if (c16 !== 16'd0) $display("FAIL const_low_b: got %0d want 0", c16); else npass++;
    repeat (50) @(negedge clk);
    sig = 1'b1;
    wait_valid(n);
    ntotal++; if (c16 !== 16'd1) $display("FAIL const_rise: got %0d want 1", c16); else npass++;
    wait_valid(n);
    ntotal++; if (c16 !== 16'd0) $display("FAIL const_high: got %0d want 0", c16); else npass++;
  endtask
  task automatic test_boundary;
    int n;
    sig = 1'b0;
    wait_valid(n);
    repeat (97) @(negedge clk);
    sig = 1'b1;
    wait_valid(n);
    ntotal++; if (n != 3) $display("FAIL bound_last_timing: got %0d want 3", n); else npass++;
    ntotal++; if (c16 !== 16'd1) $display("FAIL bound_last_included: got %0d want 1", c16); else npass++;
    sig = 1'b0;
    repeat (98) @(negedge clk);
    sig = 1'b1;
    wait_valid(n);
    ntotal++; if (n != 2) $display("FAIL bound_late_timing: got %0d want 2", n); else npass++;
    ntotal++; if (c16 !== 16'd0) $display("FAIL bound_late_excluded: got %0d want 0", c16); else npass++;
    wait_valid(n);
    ntotal++; if (c16 !== 16'd1) $display("FAIL bound_late_carried: got %0d want 1", c16); else npass++;
  endtask
  initial begin
    test_reset();
    test_steady();
    test_enable_drop();
    test_reset_mid();
    test_overflow();
    test_constant();
    test_boundary();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
